// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg : shared funct3 codes, arbiter states and legality helper    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DUMP   = 2'd2;

    // Unsigned widths only exist for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = ~we;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_lane_align : store lane shift/mask, load extract/extend, errors  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rd,
    output logic [3:0]  wmask,
    output logic [31:0] wd,
    output logic [31:0] rdata,
    output logic        err
);

    logic        misaligned;
    logic [4:0]  shamt;
    logic [31:0] rd_sh;

    assign shamt = {offset, 3'b000};
    assign rd_sh = rd >> shamt;

    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            F3_H, F3_HU: misaligned = offset[0];
            F3_W:        misaligned = |offset;
            default:     misaligned = 1'b0;
        endcase
    end

    assign err = misaligned | ~f3_legal(we, funct3);

    // Errored accesses produce no lanes and no data in either direction.
    always_comb begin
        wmask = 4'b0000;
        wd    = 32'h0;
        rdata = 32'h0;
        if (!err) begin
            case (funct3)
                F3_B: begin
                    wmask = 4'b0001 << offset;
                    wd    = {24'h0, wdata[7:0]} << shamt;
                    rdata = {{24{rd_sh[7]}}, rd_sh[7:0]};
                end
                F3_H: begin
                    wmask = 4'b0011 << offset;
                    wd    = {16'h0, wdata[15:0]} << shamt;
                    rdata = {{16{rd_sh[15]}}, rd_sh[15:0]};
                end
                F3_W: begin
                    wmask = 4'b1111;
                    wd    = wdata;
                    rdata = rd;
                end
                F3_BU:   rdata = {24'h0, rd_sh[7:0]};
                F3_HU:   rdata = {16'h0, rd_sh[15:0]};
                default: rdata = 32'h0;
            endcase
            if (we) begin
                rdata = 32'h0;
            end else begin
                wmask = 4'b0000;
                wd    = 32'h0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter : two-port data memory front end with dump sequencing    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit FAIR   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [2:0]        m0_funct3,
    input  logic [2:0]        m1_funct3,
    input  logic [31:0]       m0_wdata,
    input  logic [31:0]       m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rsp_valid,
    output logic              m1_rsp_valid,
    output logic [31:0]       m0_rdata,
    output logic [31:0]       m1_rdata,
    output logic              m0_err,
    output logic              m1_err,
    input  logic              dump_req,
    output logic              mem_we,
    output logic [3:0]        mem_wmask,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd,
    output logic              mem_dump
);

    state_t              state;
    logic                dump_pending;
    logic                last_grant;
    logic                owner;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [2:0]          acc_f3;
    logic [31:0]         acc_wdata;

    logic                rsp_valid;
    logic                rsp_owner;
    logic                rsp_err;
    logic [31:0]         rsp_rdata;

    logic                sel;
    logic                grant;
    logic                in_access;
    logic [3:0]          la_wmask;
    logic [31:0]         la_wd;
    logic [31:0]         la_rdata;
    logic                la_err;

    // sel = index of the port that wins if a grant happens this cycle.
    always_comb begin
        if (m0_req && m1_req) begin
            sel = FAIR ? ~last_grant : 1'b0;
        end else begin
            sel = m1_req;
        end
    end

    assign grant  = (state == ST_IDLE) && !dump_pending && (m0_req || m1_req);
    assign m0_gnt = grant & ~sel;
    assign m1_gnt = grant & sel;

    dmem_lane_align u_align (
        .we     (acc_we),
        .offset (acc_addr[1:0]),
        .funct3 (acc_f3),
        .wdata  (acc_wdata),
        .rd     (mem_rd),
        .wmask  (la_wmask),
        .wd     (la_wd),
        .rdata  (la_rdata),
        .err    (la_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dump_pending <= 1'b0;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            acc_we       <= 1'b0;
            acc_addr     <= '0;
            acc_f3       <= 3'b000;
            acc_wdata    <= 32'h0;
            rsp_valid    <= 1'b0;
            rsp_owner    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= 32'h0;
        end else begin
            rsp_valid    <= 1'b0;
            // A request landing in the DUMP cycle itself survives the clear.
            dump_pending <= dump_req | (dump_pending & (state != ST_DUMP));
            case (state)
                ST_IDLE: begin
                    if (dump_pending) begin
                        state <= ST_DUMP;
                    end else if (m0_req || m1_req) begin
                        state     <= ST_ACCESS;
                        owner     <= sel;
                        acc_we    <= sel ? m1_we     : m0_we;
                        acc_addr  <= sel ? m1_addr   : m0_addr;
                        acc_f3    <= sel ? m1_funct3 : m0_funct3;
                        acc_wdata <= sel ? m1_wdata  : m0_wdata;
                    end
                end
                ST_ACCESS: begin
                    rsp_valid  <= 1'b1;
                    rsp_owner  <= owner;
                    rsp_err    <= la_err;
                    rsp_rdata  <= la_rdata;
                    last_grant <= owner;
                    state      <= ST_IDLE;
                end
                ST_DUMP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_access = (state == ST_ACCESS);
    assign mem_we    = in_access & acc_we & ~la_err;
    assign mem_wmask = in_access ? la_wmask : 4'b0000;
    assign mem_wd    = in_access ? la_wd : 32'h0;
    assign mem_addr  = in_access ? acc_addr[ADDR_W-1:2] : '0;
    assign mem_dump  = (state == ST_DUMP);

    assign m0_rsp_valid = rsp_valid & ~rsp_owner;
    assign m1_rsp_valid = rsp_valid & rsp_owner;
    assign m0_err       = m0_rsp_valid & rsp_err;
    assign m1_err       = m1_rsp_valid & rsp_err;
    assign m0_rdata     = m0_rsp_valid ? rsp_rdata : 32'h0;
    assign m1_rdata     = m1_rsp_valid ? rsp_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter : directed bench with transaction-level memory model  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

    localparam int AW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          m0_req, m1_req, m0_we, m1_we, dump_req;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [2:0]    m0_funct3, m1_funct3;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rsp_valid, m1_rsp_valid, m0_err, m1_err;
    logic [31:0]   m0_rdata, m1_rdata, mem_wd, mem_rd;
    logic          mem_we, mem_dump;
    logic [3:0]    mem_wmask;
    logic [AW-3:0] mem_addr;

    logic          f_m0_gnt, f_m1_gnt, f_m0_rv, f_m1_rv, f_m0_err, f_m1_err, f_we, f_dump;
    logic [31:0]   f_m0_rd, f_m1_rd, f_wd;
    logic [3:0]    f_wmask;
    logic [AW-3:0] f_addr;
    logic          zero1  = 1'b0;
    logic [31:0]   zero32 = 32'h0;

    dmem_arbiter #(.ADDR_W(AW), .FAIR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_funct3(m0_funct3), .m1_funct3(m1_funct3),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rsp_valid(m0_rsp_valid), .m1_rsp_valid(m1_rsp_valid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_err(m0_err), .m1_err(m1_err),
        .dump_req(dump_req), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_dump(mem_dump)
    );

    // Fixed-priority instance shares the request inputs.
    dmem_arbiter #(.ADDR_W(AW), .FAIR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_funct3(m0_funct3), .m1_funct3(m1_funct3),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_gnt(f_m0_gnt), .m1_gnt(f_m1_gnt),
        .m0_rsp_valid(f_m0_rv), .m1_rsp_valid(f_m1_rv),
        .m0_rdata(f_m0_rd), .m1_rdata(f_m1_rd), .m0_err(f_m0_err), .m1_err(f_m1_err),
        .dump_req(zero1), .mem_we(f_we), .mem_wmask(f_wmask), .mem_addr(f_addr),
        .mem_wd(f_wd), .mem_rd(zero32), .mem_dump(f_dump)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] init_word(input int i);
        return (i == 25) ? 32'h84755779 : 32'hA5000000 + 32'(i) * 32'h00010101;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = size_of(f3);
        if (sz == 0) return 1'b1;
        if (we && f3[2]) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input logic [2:0] f3);
        int sz, off;
        logic [31:0] v, m;
        sz  = size_of(f3);
        off = int'(a % 4);
        if (sz == 4) return word;
        m = 32'd1 << (8 * sz);
        v = (word >> (8 * off)) % m;
        if (!f3[2] && v >= m / 2) v = v - m;
        return v;
    endfunction

    function automatic logic [3:0] model_mask(input logic [31:0] a, input logic [2:0] f3);
        logic [3:0] r;
        int off;
        r = 4'b0000;
        off = int'(a % 4);
        for (int i = 0; i < size_of(f3); i++) r[off + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] model_wd(input logic [31:0] a, input logic [2:0] f3,
                                             input logic [31:0] wdata);
        logic [31:0] r;
        int off;
        r = 32'h0;
        off = int'(a % 4);
        for (int i = 0; i < size_of(f3); i++) r[8*(off+i) +: 8] = wdata[8*i +: 8];
        return r;
    endfunction

    // ---------------- memory seen by the DUT ----------------
    logic [31:0] phys_mem [64];
    assign mem_rd = phys_mem[mem_addr[5:0]];

    initial begin
        for (int i = 0; i < 64; i++) phys_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) phys_mem[mem_addr[5:0]][8*b +: 8] = mem_wd[8*b +: 8];
            end
        end
    end

    // ---------------- per-cycle compare process ----------------
    typedef struct {
        int          due;
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
    } acc_t;

    acc_t        pend[$];
    logic [31:0] model_mem [64];

    initial begin
        acc_t        e;
        int          idx;
        logic        perr, exp_st, rv0, rv1;
        logic [31:0] prd;
        for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                chk("reset_ctrl_outputs", {20'h0, m0_gnt, m1_gnt, m0_rsp_valid, m1_rsp_valid,
                    m0_err, m1_err, mem_we, mem_dump, mem_wmask}, 32'h0);
                chk("reset_data_outputs", m0_rdata | m1_rdata | mem_wd | {2'b00, mem_addr}, 32'h0);
            end else begin
                rv0 = 1'b0;
                rv1 = 1'b0;
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    e    = pend.pop_front();
                    idx  = int'((e.addr / 4) % 64);
                    perr = model_err(e.we, e.f3, e.addr);
                    prd  = (e.we || perr) ? 32'h0 : model_load(model_mem[idx], e.addr, e.f3);
                    if (e.we && !perr)
                        for (int b = 0; b < 4; b++)
                            if (model_mask(e.addr, e.f3)[b])
                                model_mem[idx][8*b +: 8] = model_wd(e.addr, e.f3, e.wdata)[8*b +: 8];
                    if (e.port == 0) begin
                        rv0 = 1'b1;
                        chk("m0_rdata", m0_rdata, prd);
                        chk("m0_err", {31'h0, m0_err}, {31'h0, perr});
                    end else begin
                        rv1 = 1'b1;
                        chk("m1_rdata", m1_rdata, prd);
                        chk("m1_err", {31'h0, m1_err}, {31'h0, perr});
                    end
                    chk("mem_word", phys_mem[idx], model_mem[idx]);
                end
                chk("m0_rsp_valid", {31'h0, m0_rsp_valid}, {31'h0, rv0});
                chk("m1_rsp_valid", {31'h0, m1_rsp_valid}, {31'h0, rv1});

                if (pend.size() > 0 && pend[0].due == cyc + 1) begin
                    e      = pend[0];
                    perr   = model_err(e.we, e.f3, e.addr);
                    exp_st = e.we && !perr;
                    chk("acc_mem_addr", {2'b00, mem_addr}, e.addr >> 2);
                    chk("acc_mem_we", {31'h0, mem_we}, {31'h0, exp_st});
                    if (exp_st) begin
                        chk("acc_mem_wmask", {28'h0, mem_wmask}, {28'h0, model_mask(e.addr, e.f3)});
                        chk("acc_mem_wd", mem_wd, model_wd(e.addr, e.f3, e.wdata));
                    end else if (perr) begin
                        chk("err_mem_wmask", {28'h0, mem_wmask}, 32'h0);
                    end
                end else begin
                    chk("idle_mem_we_wmask", {27'h0, mem_we, mem_wmask}, 32'h0);
                end

                chk("gnt_sanity", {31'h0, (m0_gnt && !m0_req) || (m1_gnt && !m1_req) ||
                    (m0_gnt && m1_gnt)}, 32'h0);
                if (m0_gnt) pend.push_back('{cyc + 2, 0, m0_we, m0_addr, m0_funct3, m0_wdata});
                if (m1_gnt) pend.push_back('{cyc + 2, 1, m1_we, m1_addr, m1_funct3, m1_wdata});
            end
        end
    end

    // Fixed-priority instance: grants seen while both ports request.
    int fp_g0 = 0;
    int fp_g1 = 0;
    always @(negedge clk) begin
        if (rst_n && m0_req && m1_req) begin
            if (f_m0_gnt) fp_g0 <= fp_g0 + 1;
            if (f_m1_gnt) fp_g1 <= fp_g1 + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_port(input int port, input logic req, input logic we, input logic [31:0] addr,
                            input logic [2:0] f3, input logic [31:0] wd);
        if (port == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_funct3 = f3; m0_wdata = wd;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_funct3 = f3; m1_wdata = wd;
        end
    endtask

    task automatic do_acc(input int port, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic a_we, output logic [3:0] a_mask,
                          output logic [31:0] a_wd, output logic [31:0] a_addr);
        int gc;
        gc = -1; lat = -1; rdata = 32'h0; err = 1'b0;
        a_we = 1'b0; a_mask = 4'h0; a_wd = 32'h0; a_addr = 32'h0;
        @(posedge clk); #1;
        set_port(port, 1'b1, we, addr, f3, wd);
        for (int i = 0; i < 20 && gc < 0; i++) begin
            @(negedge clk);
            if ((port == 0) ? m0_gnt : m1_gnt) gc = cyc;
        end
        @(posedge clk); #1;
        if (port == 0) m0_req = 1'b0; else m1_req = 1'b0;
        if (gc < 0) begin
            note_fail("gnt_wait");
            return;
        end
        @(negedge clk);
        a_we = mem_we; a_mask = mem_wmask; a_wd = mem_wd; a_addr = {2'b00, mem_addr};
        for (int i = 0; i < 5 && lat < 0; i++) begin
            @(negedge clk);
            if ((port == 0) ? m0_rsp_valid : m1_rsp_valid) begin
                lat   = cyc - gc;
                rdata = (port == 0) ? m0_rdata : m1_rdata;
                err   = (port == 0) ? m0_err : m1_err;
            end
        end
        if (lat < 0) note_fail("rsp_wait");
    endtask

    initial begin
        logic [31:0] rd, awd, aad;
        logic        er, awe;
        logic [3:0]  amk;
        int          lat, n, dc, ng, d2, nd;
        int          seq [4];

        set_port(0, 1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
        set_port(1, 1'b0, 1'b0, 32'h0, 3'b010, 32'h0);
        dump_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_addr", {2'b00, mem_addr}, 32'h0);
        chk("reset_mem_dump", {31'h0, mem_dump}, 32'h0);
        rst_n = 1'b1;

        // Both ports request continuously: first tie goes to port 0.
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 32'h64, 3'b010, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h20, 3'b010, 32'h0);
        n = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(negedge clk);
            if (m0_gnt) begin seq[n] = 0; n++; end
            else if (m1_gnt) begin seq[n] = 1; n++; end
        end
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        if (n < 4) note_fail("fair_grants");
        else for (int k = 0; k < 4; k++) chk("fair_order", seq[k], k % 2);
        chk("fixed_prio_m1_never", fp_g1, 0);
        chk("fixed_prio_m0_served", {31'h0, fp_g0 >= 3}, 32'h1);
        repeat (3) @(posedge clk);

        // Loads from word 25 = 0x84755779.
        do_acc(0, 1'b0, 32'h65, 3'b000, 32'h0, rd, er, lat, awe, amk, awd, aad);
        chk("lb_0x65", rd, 32'h00000057);
        chk("lb_0x65_latency", lat, 2);
        do_acc(0, 1'b0, 32'h67, 3'b000, 32'h0, rd, er, lat, awe, amk, awd, aad);
        chk("lb_0x67", rd, 32'hFFFFFF84);
        chk("lb_0x67_latency", lat, 2);
        do_acc(0, 1'b0, 32'h66, 3'b101, 32'h0, rd, er, lat, awe, amk, awd, aad);
        chk("lhu_0x66", rd, 32'h00008475);
        chk("lhu_0x66_latency", lat, 2);
        do_acc(0, 1'b0, 32'h64, 3'b010, 32'h0, rd, er, lat, awe, amk, awd, aad);
        chk("lw_0x64", rd, 32'h84755779);
        chk("lw_0x64_latency", lat, 2);
        do_acc(0, 1'b0, 32'h66, 3'b001, 32'h0, rd, er, lat, awe, amk, awd, aad);
        chk("lh_0x66", rd, 32'hFFFF8475);

        // Byte store then read-back.
        do_acc(1, 1'b1, 32'h66, 3'b000, 32'h000000AB, rd, er, lat, awe, amk, awd, aad);
        chk("sb_mem_addr", aad, 32'd25);
        chk("sb_mem_wmask", {28'h0, amk}, 32'h4);
        chk("sb_mem_wd", awd, 32'h00AB0000);
        chk("sb_mem_we", {31'h0, awe}, 32'h1);
        chk("sb_rdata", rd, 32'h0);
        do_acc(0, 1'b0, 32'h64, 3'b010, 32'h0, rd, er, lat, awe, amk, awd, aad);
        chk("lw_after_sb", rd, 32'h84AB5779);

        do_acc(1, 1'b1, 32'h42, 3'b001, 32'hFFFF1234, rd, er, lat, awe, amk, awd, aad);
        chk("sh_0x42_wmask", {28'h0, amk}, 32'hC);
        chk("sh_0x42_wd", awd, 32'h12340000);

        // Error accesses.
        do_acc(0, 1'b0, 32'h62, 3'b010, 32'h0, rd, er, lat, awe, amk, awd, aad);
        chk("lw_misaligned_err", {31'h0, er}, 32'h1);
        chk("lw_misaligned_rdata", rd, 32'h0);
        chk("lw_misaligned_latency", lat, 2);
        do_acc(1, 1'b1, 32'h03, 3'b001, 32'h0000BEEF, rd, er, lat, awe, amk, awd, aad);
        chk("sh_misaligned_err", {31'h0, er}, 32'h1);
        chk("sh_misaligned_we", {27'h0, awe, amk}, 32'h0);
        chk("sh_misaligned_mem", phys_mem[0], 32'hA5000000);
        do_acc(0, 1'b1, 32'h10, 3'b100, 32'h11, rd, er, lat, awe, amk, awd, aad);
        chk("store_bu_illegal", {30'h0, er, awe}, 32'h2);
        do_acc(0, 1'b0, 32'h10, 3'b011, 32'h0, rd, er, lat, awe, amk, awd, aad);
        chk("f3_011_illegal", {31'h0, er}, 32'h1);

        // Dump while m0 keeps requesting.
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 32'h64, 3'b010, 32'h0);
        ng = -1;
        for (int i = 0; i < 20 && ng < 0; i++) begin
            @(negedge clk);
            if (m0_gnt) ng = cyc;
        end
        if (ng < 0) note_fail("dump_first_gnt");
        @(posedge clk); #1; dump_req = 1'b1;
        @(posedge clk); #1; dump_req = 1'b0;
        @(negedge clk);
        chk("dump_blocks_gnt", {31'h0, m0_gnt}, 32'h0);
        dc = -1; ng = -1;
        for (int i = 0; i < 8 && ng < 0; i++) begin
            @(negedge clk);
            if (mem_dump && dc < 0) dc = cyc;
            if (m0_gnt && dc >= 0) begin
                ng = cyc;
                chk("dump_one_cycle", {31'h0, mem_dump}, 32'h0);
            end
        end
        if (ng < 0 || dc < 0) note_fail("dump_then_gnt");
        else chk("dump_before_gnt", ng - dc, 1);

        @(posedge clk); #1; dump_req = 1'b1;
        @(posedge clk); #1; dump_req = 1'b0;
        dc = -1;
        for (int i = 0; i < 8 && dc < 0; i++) begin
            @(negedge clk);
            if (mem_dump) dc = cyc;
        end
        if (dc < 0) note_fail("dump_second_wait");
        dump_req = 1'b1;
        @(posedge clk); #1; dump_req = 1'b0;
        nd = 0; d2 = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_dump) begin nd++; d2 = cyc; end
        end
        @(posedge clk); #1; m0_req = 1'b0;
        chk("redump_count", nd, 1);
        chk("redump_cycle", d2 - dc, 2);
        repeat (4) @(posedge clk);

        // Reset during the ACCESS cycle of a store.
        @(posedge clk); #1;
        set_port(1, 1'b1, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
        ng = -1;
        for (int i = 0; i < 20 && ng < 0; i++) begin
            @(negedge clk);
            if (m1_gnt) ng = cyc;
        end
        if (ng < 0) note_fail("rst_store_gnt");
        @(posedge clk); #2;
        chk("pre_reset_we", {31'h0, mem_we}, 32'h1);
        rst_n = 1'b0;
        m1_req = 1'b0;
        #1;
        chk("async_reset_we_mask", {27'h0, mem_we, mem_wmask}, 32'h0);
        chk("async_reset_addr_wd", mem_wd | {2'b00, mem_addr}, 32'h0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        chk("aborted_store_mem", phys_mem[4], 32'hA5040404);
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 32'h64, 3'b010, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h20, 3'b010, 32'h0);
        ng = -1;
        for (int i = 0; i < 10 && ng < 0; i++) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                ng = cyc;
                chk("tie_after_reset", {30'h0, m0_gnt, m1_gnt}, 32'h2);
            end
        end
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        if (ng < 0) note_fail("tie_after_reset_wait");
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
